// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronizes SDA/SCL, detects START/STOP, decodes
// bytes with their ACK bit and keeps frame and NACK statistics.
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 sda_in,
   input  logic                 scl_in,
   output logic                 start_det,
   output logic                 stop_det,
   output logic                 byte_valid,
   output logic [7:0]           byte_data,
   output logic                 byte_is_addr,
   output logic                 byte_ack,
   output logic                 rw,
   output logic                 bus_busy,
   output logic                 frame_err,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [7:0]           nack_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sdaSync_q;
   logic [SYNC_STAGES-1:0] sclSync_q;
   logic                   sdaHist_q;
   logic                   sclHist_q;
   logic                   sdaNow;
   logic                   sclNow;

   logic startStrobe_d, stopStrobe_d, riseStrobe_d, fallStrobe_d;
   logic startStrobe_q, stopStrobe_q, riseStrobe_q, fallStrobe_q;
   logic sampleBit_q;

   state_t                 state_q;
   logic [3:0]             bitCnt_q;
   logic                   openBit_q;
   logic [3:0]             committedBits;
   logic [7:0]             shiftReg_q;
   logic                   startDet_q;
   logic                   stopDet_q;
   logic                   byteValid_q;
   logic [7:0]             byteData_q;
   logic                   byteIsAddr_q;
   logic                   byteAck_q;
   logic                   rw_q;
   logic                   busBusy_q;
   logic                   frameErr_q;
   logic [CNT_WIDTH-1:0]   frameCount_q;
   logic [7:0]             nackCount_q;

   // Flops preset to 1 so an idle bus seen at reset release looks unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sdaSync_q <= '1;
         sclSync_q <= '1;
         sdaHist_q <= 1'b1;
         sclHist_q <= 1'b1;
      end else begin
         sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
         sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
         sdaHist_q <= sdaSync_q[SYNC_STAGES-1];
         sclHist_q <= sclSync_q[SYNC_STAGES-1];
      end
   end

   assign sdaNow = sdaSync_q[SYNC_STAGES-1];
   assign sclNow = sclSync_q[SYNC_STAGES-1];

   assign startStrobe_d = sclNow & sclHist_q & sdaHist_q & ~sdaNow;
   assign stopStrobe_d  = sclNow & sclHist_q & ~sdaHist_q & sdaNow;
   assign riseStrobe_d  = sclNow & ~sclHist_q;
   assign fallStrobe_d  = ~sclNow & sclHist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         startStrobe_q <= 1'b0;
         stopStrobe_q  <= 1'b0;
         riseStrobe_q  <= 1'b0;
         fallStrobe_q  <= 1'b0;
         sampleBit_q   <= 1'b0;
      end else begin
         startStrobe_q <= startStrobe_d;
         stopStrobe_q  <= stopStrobe_d;
         riseStrobe_q  <= riseStrobe_d;
         fallStrobe_q  <= fallStrobe_d;
         sampleBit_q   <= sdaNow;
      end
   end

   // The SCL high phase that carries a START/STOP was already counted as a bit
   // on its rising edge; only bits whose high phase has ended count as partial.
   assign committedBits = bitCnt_q - {3'b000, openBit_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bitCnt_q     <= 4'd0;
         openBit_q    <= 1'b0;
         shiftReg_q   <= 8'h00;
         startDet_q   <= 1'b0;
         stopDet_q    <= 1'b0;
         byteValid_q  <= 1'b0;
         byteData_q   <= 8'h00;
         byteIsAddr_q <= 1'b0;
         byteAck_q    <= 1'b0;
         rw_q         <= 1'b0;
         busBusy_q    <= 1'b0;
         frameErr_q   <= 1'b0;
         frameCount_q <= '0;
         nackCount_q  <= 8'h00;
      end else begin
         startDet_q  <= 1'b0;
         stopDet_q   <= 1'b0;
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         busBusy_q   <= enable && (state_q != IDLE);
         if (!enable) begin
            state_q   <= IDLE;
            bitCnt_q  <= 4'd0;
            openBit_q <= 1'b0;
         end else if (startStrobe_q) begin
            startDet_q <= 1'b1;
            frameErr_q <= (committedBits != 4'd0);
            state_q    <= ADDR;
            bitCnt_q   <= 4'd0;
            openBit_q  <= 1'b0;
         end else if (stopStrobe_q) begin
            stopDet_q  <= 1'b1;
            frameErr_q <= (committedBits != 4'd0);
            if (state_q != IDLE) begin
               frameCount_q <= frameCount_q + CNT_WIDTH'(1);
            end
            state_q   <= IDLE;
            bitCnt_q  <= 4'd0;
            openBit_q <= 1'b0;
         end else if (state_q != IDLE) begin
            if (riseStrobe_q) begin
               if (bitCnt_q == 4'd8) begin
                  byteValid_q  <= 1'b1;
                  byteData_q   <= shiftReg_q;
                  byteAck_q    <= ~sampleBit_q;
                  byteIsAddr_q <= (state_q == ADDR);
                  if (state_q == ADDR) begin
                     rw_q <= shiftReg_q[0];
                  end
                  if (sampleBit_q && (nackCount_q != 8'hFF)) begin
                     nackCount_q <= nackCount_q + 8'd1;
                  end
                  state_q   <= DATA;
                  bitCnt_q  <= 4'd0;
                  openBit_q <= 1'b0;
               end else begin
                  shiftReg_q <= {shiftReg_q[6:0], sampleBit_q};
                  bitCnt_q   <= bitCnt_q + 4'd1;
                  openBit_q  <= 1'b1;
               end
            end else if (fallStrobe_q) begin
               openBit_q <= 1'b0;
            end
         end
      end
   end

   assign start_det    = startDet_q;
   assign stop_det     = stopDet_q;
   assign byte_valid   = byteValid_q;
   assign byte_data    = byteData_q;
   assign byte_is_addr = byteIsAddr_q;
   assign byte_ack     = byteAck_q;
   assign rw           = rw_q;
   assign bus_busy     = busBusy_q;
   assign frame_err    = frameErr_q;
   assign frame_count  = frameCount_q;
   assign nack_count   = nackCount_q;

endmodule

// File: doc/i2c_bus_monitor.md
I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on sda_in/scl_in (legal 2..4).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of frame_count.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses one clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, monitor enable; low forces IDLE, suppresses all pulses, and holds the counters.
REQ-006 SHALL have port sda_in, input, 1, raw SDA line level (asynchronous).
REQ-007 SHALL have port scl_in, input, 1, raw SCL line level (asynchronous).
REQ-008 SHALL have port start_det, output, 1, one-cycle pulse on START or repeated START.
REQ-009 SHALL have port stop_det, output, 1, one-cycle pulse on STOP.
REQ-010 SHALL have port byte_valid, output, 1, one-cycle pulse when a complete byte plus ACK bit is decoded.
REQ-011 SHALL have port byte_data, output, 8, decoded byte, MSB first on wire; valid with byte_valid, held until the next byte.
REQ-012 SHALL have port byte_is_addr, output, 1, byte_data is the first byte after START/repeated START.
REQ-013 SHALL have port byte_ack, output, 1, 1 when the 9th bit was sampled low (ACK), 0 for NACK.
REQ-014 SHALL have port rw, output, 1, byte_data[0] of the last address byte (1 = read).
REQ-015 SHALL have port bus_busy, output, 1, high from START until STOP.
REQ-016 SHALL have port frame_err, output, 1, one-cycle pulse on START/STOP detected with bit_cnt not 0.
REQ-017 SHALL have port frame_count, output, CNT_WIDTH, count of STOP-terminated frames; wraps to 0.
REQ-018 SHALL have port nack_count, output, 8, count of NACK bytes; saturates at 255.

Function
REQ-019 SHALL pass sda_in and scl_in through SYNC_STAGES flops, then one history flop for edge detection.
REQ-020 SHALL report every event (start_det, stop_det, byte_valid, frame_err) registered, exactly SYNC_STAGES+1 clk cycles after the first clk edge that samples the new raw level.
REQ-021 SHALL detect START as synced SDA 1->0 while synced SCL is high and unchanged; STOP as SDA 0->1 under the same condition.
REQ-022 SHALL treat SDA and SCL changing in the same cycle as an SCL edge only, with no START/STOP.
REQ-023 SHALL ignore SDA changes while SCL is low.
REQ-024 SHALL sample SDA on each synced SCL rising edge in ADDR/DATA states and increment a 4-bit bit_cnt 0..8.
REQ-025 SHALL shift bits 0..7 into the byte register; bit 8 is the ACK bit; after bit 8 it pulses byte_valid and resets bit_cnt to 0.
REQ-026 SHALL use states IDLE, ADDR, and DATA with these transitions:
- IDLE->ADDR on START.
- ADDR->DATA after the ADDR byte's 9th bit.
- DATA->DATA after each byte.
- ADDR/DATA->ADDR on repeated START.
- ADDR/DATA->IDLE on STOP.
- any state->IDLE when enable=0.
REQ-027 SHALL set byte_is_addr=1 only for bytes completed in ADDR; rw updates on those bytes only.
REQ-028 SHALL, on START/STOP with bit_cnt not 0, pulse frame_err in the same cycle as start_det/stop_det, discard the partial byte (no byte_valid), and still take the START/STOP transition.
REQ-029 SHALL increment frame_count on stop_det only when the state was ADDR or DATA; a STOP in IDLE pulses stop_det without counting.
REQ-030 SHALL increment nack_count when byte_valid fires with byte_ack=0, saturating at 255.
REQ-031 SHALL drive bus_busy high the cycle after start_det and low the cycle after stop_det or when enable=0.
REQ-032 SHALL not drive SDA or SCL; the block is purely passive.

Reset
REQ-033 SHALL, on reset, clear all outputs and counters to 0, state to IDLE, and bit_cnt to 0.
REQ-034 SHALL initialize sync/history flops to 1 (idle bus) on reset, so releasing reset with lines high produces no event.
REQ-035 SHALL, on reset asserted mid-frame, abandon the frame with no byte_valid, frame_err, or frame_count change; decoding resumes only at the next START.

Verification
REQ-036 SHALL cover a write frame: START, 0xA0 ACK, 0x5A ACK, STOP -> start_det; byte 0xA0 (is_addr=1, rw=0, ack=1); byte 0x5A (is_addr=0); stop_det; frame_count=1.
REQ-037 SHALL cover a read frame: START, 0xA1 ACK, 0x3C NACK, STOP -> rw=1; second byte ack=0; nack_count=1; frame_count increments.
REQ-038 SHALL cover a repeated START: START, 0xA0, 0x01, Sr, 0xA1, 0xFF NACK, STOP -> two start_det; 0xA1 is_addr=1; one frame counted.
REQ-039 SHALL cover an abort: STOP after 4 bits of a data byte -> frame_err with stop_det, no byte_valid, state IDLE.
REQ-040 SHALL cover reset mid-frame: reset during bit 5 of a data byte -> all outputs 0; a following clean frame decodes correctly with frame_count=1.
REQ-041 SHALL cover latency and saturation: a measured event latency of exactly SYNC_STAGES+1 cycles, and 260 NACK bytes -> nack_count=255.
